// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game blocks.
// - timer_state_t : round timer FSM states (IDLE=0, RUN=1, DONE=2)
// - TIME_W        : width of seconds values shown on the play page
// - *_DEF         : default clock rate, round length and warning threshold
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int unsigned TIME_W        = 5;
    localparam int unsigned CLK_HZ_DEF    = 100_000_000;
    localparam int unsigned ROUND_SEC_DEF = 30;
    localparam int unsigned WARN_SEC_DEF  = 5;

endpackage

// File: rtl/bin5_to_bcd.sv
// Combinational 5-bit binary to two-digit BCD converter.
// - bin  in  5  value 0..31
// - tens out 4  tens digit (0..3)
// - ones out 4  ones digit (0..9)
module bin5_to_bcd
    import game_pkg::*;
(
    input  logic [TIME_W-1:0] bin,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    logic [TIME_W-1:0] rem;

    // At most three subtract-10 steps are needed for a value up to 31.
    always_comb begin
        rem  = bin;
        tens = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (rem >= TIME_W'(10)) begin
                rem  = rem - TIME_W'(10);
                tens = tens + 4'd1;
            end
        end
        ones = rem[3:0];
    end

endmodule

// File: rtl/round_timer.sv
// Round countdown timer for the whack-a-mole game.
// - clk          in   system clock
// - reset        in   asynchronous active-low reset
// - start        in   level from start page; a rising edge starts a round
// - restart      in   level from end page; returns DONE to IDLE
// - time_display out  seconds remaining (5 bits)
// - bcd_tens     out  tens digit of time_display
// - bcd_ones     out  ones digit of time_display
// - tick_1s      out  one-cycle pulse on each second decrement
// - warn         out  low-time warning while running
// - pause        out  high while the round is over
module round_timer
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
    parameter int unsigned ROUND_SEC = ROUND_SEC_DEF,
    parameter int unsigned WARN_SEC  = WARN_SEC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              restart,
    output logic [TIME_W-1:0] time_display,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic              tick_1s,
    output logic              warn,
    output logic              pause
);

    localparam int unsigned       PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_HZ - 1);
    localparam logic [TIME_W-1:0] T_FULL   = TIME_W'(ROUND_SEC);
    localparam logic [TIME_W-1:0] T_WARN   = TIME_W'(WARN_SEC);
    localparam logic [3:0]        TENS_RST = 4'(ROUND_SEC / 10);
    localparam logic [3:0]        ONES_RST = 4'(ROUND_SEC % 10);

    timer_state_t      state, state_next;
    logic [PRE_W-1:0]  pre, pre_next;
    logic              start_d;
    logic              start_rise;
    logic [TIME_W-1:0] time_next;
    logic [3:0]        tens_next, ones_next;
    logic              tick_next, warn_next, pause_next;

    assign start_rise = start & ~start_d;

    // Digits are converted from the next value so they register together
    // with time_display and are never a cycle behind it.
    bin5_to_bcd u_bcd (
        .bin  (time_next),
        .tens (tens_next),
        .ones (ones_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pre          <= '0;
            start_d      <= 1'b0;
            time_display <= T_FULL;
            bcd_tens     <= TENS_RST;
            bcd_ones     <= ONES_RST;
            tick_1s      <= 1'b0;
            warn         <= 1'b0;
            pause        <= 1'b0;
        end else begin
            state        <= state_next;
            pre          <= pre_next;
            start_d      <= start;
            time_display <= time_next;
            bcd_tens     <= tens_next;
            bcd_ones     <= ones_next;
            tick_1s      <= tick_next;
            warn         <= warn_next;
            pause        <= pause_next;
        end
    end

    always_comb begin
        state_next = state;
        pre_next   = '0;
        time_next  = time_display;
        tick_next  = 1'b0;
        pause_next = 1'b0;

        case (state)
            IDLE: begin
                time_next = T_FULL;
                if (start_rise) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (pre == PRE_MAX) begin
                    tick_next = 1'b1;
                    time_next = time_display - TIME_W'(1);
                    // Last second: enter DONE on the same edge that shows 0.
                    if (time_display == TIME_W'(1)) begin
                        state_next = DONE;
                        pause_next = 1'b1;
                    end
                end else begin
                    pre_next = pre + PRE_W'(1);
                end
            end
            DONE: begin
                time_next  = '0;
                pause_next = 1'b1;
                if (restart) begin
                    state_next = IDLE;
                    time_next  = T_FULL;
                    pause_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                time_next  = T_FULL;
            end
        endcase

        warn_next = (state_next == RUN) && (time_next != '0) && (time_next <= T_WARN);
    end

endmodule

// File: tb/tb_round_timer.sv
module tb_round_timer;

    localparam int A_HZ   = 4;
    localparam int A_SEC  = 3;
    localparam int A_WARN = 1;
    localparam int B_HZ   = 4;
    localparam int B_SEC  = 30;
    localparam int B_WARN = 5;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       rst_a, start_a, restart_a;
    logic [4:0] time_a;
    logic [3:0] tens_a, ones_a;
    logic       tick_a, warn_a, pause_a;

    logic       rst_b, start_b, restart_b;
    logic [4:0] time_b;
    logic [3:0] tens_b, ones_b;
    logic       tick_b, warn_b, pause_b;

    typedef struct {
        int cyc;
        int t;
        int w;
        int p;
    } exp_t;

    exp_t q[$];

    round_timer #(.CLK_HZ(A_HZ), .ROUND_SEC(A_SEC), .WARN_SEC(A_WARN)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .restart(restart_a),
        .time_display(time_a), .bcd_tens(tens_a), .bcd_ones(ones_a),
        .tick_1s(tick_a), .warn(warn_a), .pause(pause_a)
    );

    round_timer #(.CLK_HZ(B_HZ), .ROUND_SEC(B_SEC), .WARN_SEC(B_WARN)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .restart(restart_b),
        .time_display(time_b), .bcd_tens(tens_b), .bcd_ones(ones_b),
        .tick_1s(tick_b), .warn(warn_b), .pause(pause_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: start seen before edge c+1 enters RUN; second m ends
    // CLK_HZ*m cycles later, showing A_SEC-m on the following negedge.
    task automatic push_round(input int c);
        for (int m = 1; m <= A_SEC; m++) begin
            exp_t e;
            e.cyc = c + 1 + A_HZ * m;
            e.t   = A_SEC - m;
            e.w   = (e.t > 0 && e.t <= A_WARN) ? 1 : 0;
            e.p   = (e.t == 0) ? 1 : 0;
            q.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
        chk(nm, q.size(), 0);
    endtask

    task automatic chk_idle_a(input string nm);
        chk({nm, "_time"}, time_a, A_SEC);
        chk({nm, "_pause"}, pause_a, 0);
    endtask

    // Monitor: every tick_1s pulse must match the next queued second.
    always @(negedge clk) begin
        if (rst_a === 1'b1 && tick_a === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_tick", tick_a, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_time", time_a, e.t);
                chk("tick_warn", warn_a, e.w);
                chk("tick_pause", pause_a, e.p);
                chk("tick_tens", tens_a, e.t / 10);
                chk("tick_ones", ones_a, e.t % 10);
            end
        end
    end

    task automatic run_a();
        int c;
        rst_a = 1'b0; start_a = 1'b0; restart_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_time", time_a, A_SEC);
        chk("rst_tens", tens_a, A_SEC / 10);
        chk("rst_ones", ones_a, A_SEC % 10);
        chk("rst_pause", pause_a, 0);
        chk("rst_warn", warn_a, 0);
        chk("rst_tick", tick_a, 0);
        rst_a = 1'b1;
        repeat (20) @(negedge clk);
        chk_idle_a("idle_hold");

        // Round 1 with ignored restart pulse and start re-edge during RUN.
        repeat ($urandom_range(0, 4)) @(negedge clk);
        start_a = 1'b1;
        c = cyc;
        push_round(c);
        repeat (6) @(negedge clk);
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        start_a   = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        drain("round1_drain");
        repeat ($urandom_range(1, 4)) @(negedge clk);
        chk("done_pause", pause_a, 1);
        chk("done_time", time_a, 0);
        chk("done_warn", warn_a, 0);
        chk("done_tick", tick_a, 0);

        // Restart with start still high: back to IDLE, no new round.
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        chk_idle_a("restart");
        repeat (10) @(negedge clk);
        chk_idle_a("restart_hold");

        // Round 2 to reach DONE again.
        start_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        c = cyc;
        push_round(c);
        drain("round2_drain");
        repeat (2) @(negedge clk);
        chk("done2_pause", pause_a, 1);

        // Start edge and restart together in DONE: restart wins.
        start_a = 1'b0;
        @(negedge clk);
        start_a   = 1'b1;
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        chk_idle_a("both");
        repeat (10) @(negedge clk);
        chk_idle_a("both_hold");

        // Round 3 aborted by reset while time=1.
        start_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        c = cyc;
        push_round(c);
        repeat (9 + $urandom_range(1, 3)) @(negedge clk);
        chk("pre_reset_time", time_a, 1);
        chk("pre_reset_warn", warn_a, 1);
        #1;
        rst_a = 1'b0;
        q.delete();
        #1;
        chk("async_time", time_a, A_SEC);
        chk("async_pause", pause_a, 0);
        chk("async_warn", warn_a, 0);
        chk("async_tick", tick_a, 0);
        chk("async_ones", ones_a, A_SEC % 10);
        @(negedge clk);
        rst_a   = 1'b1;
        start_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        c = cyc;
        push_round(c);
        drain("round4_drain");
        repeat (2) @(negedge clk);
        chk("done4_pause", pause_a, 1);
        chk("done4_time", time_a, 0);
    endtask

    // Long round: digits and time tracked against a cycle-count model.
    task automatic run_b();
        int c;
        rst_b = 1'b0; start_b = 1'b0; restart_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_rst_time", time_b, B_SEC);
        chk("b_rst_tens", tens_b, B_SEC / 10);
        chk("b_rst_ones", ones_b, B_SEC % 10);
        rst_b = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start_b = 1'b1;
        c = cyc;
        for (int i = 0; i <= B_HZ * B_SEC + 10; i++) begin
            int k, e;
            k = cyc - c - 1;
            e = (k < 0) ? B_SEC : B_SEC - k / B_HZ;
            if (e < 0) e = 0;
            chk("b_time", time_b, e);
            chk("b_tens", tens_b, e / 10);
            chk("b_ones", ones_b, e % 10);
            chk("b_pause", pause_b, (e == 0) ? 1 : 0);
            chk("b_warn", warn_b, (k >= 0 && e > 0 && e <= B_WARN) ? 1 : 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
